posicao: RTL and testbench
==========================

// Module: posicao
// PURPOSE
// - Grid position tracker; sits directly downstream of the avanco stage and consumes its acao codes.
// - Each valid acao sample moves the robot one cell (N/O/L/S) inside a LARG x ALT grid.
// - Flags wall hits, detects arrival at a target cell and counts successful steps.
// - Outputs feed the display/controller stage.
// PARAMETERS
// - LARG  8  grid width in cells; x range 0..LARG-1
// - ALT   8  grid height in cells; y range 0..ALT-1
// - X0    0  x coordinate after reset
// - Y0    0  y coordinate after reset
// - WX    $clog2(LARG)  x coordinate width
// - WY    $clog2(ALT)   y coordinate width
// PORTS
// - c4             in   1   clock; all state updates on posedge
// - reset          in   1   synchronous, active-high; one clock, no other clock domains
// - acao           in   3   000 parado, 001 N, 010 O, 011 L, 100 S; 101..111 invalid
// - alvo_x         in   WX  target x coordinate
// - alvo_y         in   WY  target y coordinate
// - novo_alvo      in   1   pulse; releases the CHEGOU state
// - x              out  WX  current x (registered)
// - y              out  WY  current y (registered)
// - bloqueado      out  1   high while in BATEU
// - chegou         out  1   high while in CHEGOU
// - acao_invalida  out  1   one-cycle pulse on an invalid acao code
// - passos         out  8   successful-step counter, saturates at 255
// BEHAVIOUR
// - Reset (sync, wins over everything else): x=X0, y=Y0, passos=0, bloqueado=0, chegou=0, acao_invalida=0, state=LIVRE.
// - Step requests: every posedge c4 with acao in 001..100 is one step request; a held acao steps every cycle.
// - Direction mapping: N y+1, S y-1, L x+1, O x-1. Target cell is compared against 0..LARG-1 and 0..ALT-1; no wrap-around.
// - Latency: x/y/passos update on the same edge that samples acao (1-cycle request-to-output).
// - State LIVRE:
//   - Valid step, target cell in grid: move; passos+1, saturating at 255. If the new (x,y) equals (alvo_x,alvo_y), go to CHEGOU; chegou rises on the same edge as the move.
//   - Valid step, target cell outside grid: no move, passos unchanged, go to BATEU.
//   - acao=000 and current (x,y) equals alvo: go to CHEGOU on the next edge (this covers a target equal to the reset cell).
//   - Invalid code: acao_invalida=1 for one cycle, no move, stay in LIVRE.
// - State BATEU:
//   - bloqueado=1; every step request is ignored, including one pointing away from the wall.
//   - acao=000: go to LIVRE. bloqueado falls on that edge; an arrival check, if any, happens on the following edge.
// - State CHEGOU:
//   - chegou=1; all steps are ignored; passos is frozen.
//   - novo_alvo=1: go to LIVRE; chegou falls on that edge. A step sampled on that same edge is ignored.
// - Other rules:
//   - acao_invalida pulses in every state; it is 0 on any edge without an invalid code.
//   - alvo_x/alvo_y may change at any time; they are only compared in LIVRE.
//   - Reset during a held acao: reset applies and no step is taken on that edge.
// STRUCTURE
// - Shared package robo_pkg:
//   - acao codes PARADO/ACAO_N/ACAO_O/ACAO_L/ACAO_S (also used by avanco)
//   - orientation codes NORTE=001, OESTE=010, LESTE=011, SUL=100
//   - enum estado_pos_t {LIVRE, BATEU, CHEGOU}
// - Sub-module proxima_posicao (combinational): inputs x, y, acao; outputs nx, ny, fora_da_grade, codigo_invalido; parameterised by LARG/ALT.
// - Top: FSM, coordinate registers, saturating counter, target comparator.
// TESTING (LARG=8, ALT=8, X0=0, Y0=0 unless stated)
// 1. Reset held 2 cycles, alvo=(7,7) -> x=0, y=0, passos=0, bloqueado=0, chegou=0.
// 2. acao=001 for 3 cycles, alvo=(7,7) -> y=1,2,3 on successive edges, x=0, passos=3.
// 3. Wall hit and release, at (0,0):
//    - acao=010 -> bloqueado=1 next edge, x=0, passos unchanged.
//    - acao=011 for 2 cycles -> x stays 0.
//    - acao=000 -> bloqueado=0 next edge.
// 4. Arrival, alvo=(2,0):
//    - acao=011 for 2 cycles -> x=2 and chegou=1 on the same edge.
//    - acao=001 -> y stays 0.
//    - novo_alvo=1 with acao=001 on the same edge -> chegou=0, y=0.
//    - next acao=001 -> y=1.
// 5. Counter saturation: 300 cycles alternating acao=011/010, alvo=(7,7) -> passos=255 and stays 255.
// 6. Invalid code and reset priority:
//    - acao=101 -> acao_invalida=1 for exactly one cycle, x/y unchanged.
//    - reset=1 with acao=001 on the same edge from (3,3) -> x=0, y=0, passos=0.

Source files
------------

// File: rtl/robo_pkg.sv
// Shared definitions for the robot datapath: acao codes (shared with avanco),
// orientation codes and the position-tracker state encoding.
package robo_pkg;

  localparam int unsigned ACAO_W = 3;

  // acao codes produced by avanco
  localparam logic [ACAO_W-1:0] PARADO = 3'b000;
  localparam logic [ACAO_W-1:0] ACAO_N = 3'b001;
  localparam logic [ACAO_W-1:0] ACAO_O = 3'b010;
  localparam logic [ACAO_W-1:0] ACAO_L = 3'b011;
  localparam logic [ACAO_W-1:0] ACAO_S = 3'b100;

  // orientation codes
  localparam logic [ACAO_W-1:0] NORTE = 3'b001;
  localparam logic [ACAO_W-1:0] OESTE = 3'b010;
  localparam logic [ACAO_W-1:0] LESTE = 3'b011;
  localparam logic [ACAO_W-1:0] SUL   = 3'b100;

  localparam int unsigned PASSOS_W   = 8;
  localparam logic [PASSOS_W-1:0] PASSOS_MAX = 8'hFF;

  typedef enum logic [1:0] {
    LIVRE  = 2'd0,
    BATEU  = 2'd1,
    CHEGOU = 2'd2
  } estado_pos_t;

  // True for one of the four movement codes
  function automatic logic eh_passo(input logic [ACAO_W-1:0] a);
    return (a == ACAO_N) || (a == ACAO_O) || (a == ACAO_L) || (a == ACAO_S);
  endfunction

endpackage

// File: rtl/posicao_proxima_posicao.sv
// proxima_posicao: combinational next-cell calculator.
// Ports:
//   x, y            current coordinates
//   acao            requested action code
//   nx, ny          coordinates of the neighbouring cell in the requested direction
//                   (equal to x, y for non-step codes or when leaving the grid)
//   fora_da_grade   the requested step would leave the grid
//   codigo_invalido acao is one of the unused codes 101..111
module proxima_posicao
  import robo_pkg::*;
#(
  parameter int unsigned LARG = 8,
  parameter int unsigned ALT  = 8,
  parameter int unsigned WX   = $clog2(LARG),
  parameter int unsigned WY   = $clog2(ALT)
) (
  input  logic [WX-1:0]     x,
  input  logic [WY-1:0]     y,
  input  logic [ACAO_W-1:0] acao,
  output logic [WX-1:0]     nx,
  output logic [WY-1:0]     ny,
  output logic              fora_da_grade,
  output logic              codigo_invalido
);

  localparam logic [WX-1:0] X_MAX = WX'(LARG - 1);
  localparam logic [WY-1:0] Y_MAX = WY'(ALT - 1);

  // Boundary tests compare against the edge cells directly, so no wider
  // arithmetic is needed to detect leaving the grid.
  always_comb begin
    nx              = x;
    ny              = y;
    fora_da_grade   = 1'b0;
    codigo_invalido = 1'b0;
    case (acao)
      ACAO_N: begin
        if (y == Y_MAX) fora_da_grade = 1'b1;
        else            ny = y + WY'(1);
      end
      ACAO_S: begin
        if (y == '0) fora_da_grade = 1'b1;
        else         ny = y - WY'(1);
      end
      ACAO_L: begin
        if (x == X_MAX) fora_da_grade = 1'b1;
        else            nx = x + WX'(1);
      end
      ACAO_O: begin
        if (x == '0) fora_da_grade = 1'b1;
        else         nx = x - WX'(1);
      end
      PARADO:  ;
      default: codigo_invalido = 1'b1;
    endcase
  end

endmodule

// File: rtl/posicao.sv
// posicao: grid position tracker fed by avanco's acao codes.
// Ports:
//   c4, reset            clock and synchronous active-high reset
//   acao                 action code (000 parado, 001 N, 010 O, 011 L, 100 S)
//   alvo_x, alvo_y       target cell, compared only while LIVRE
//   novo_alvo            pulse releasing the CHEGOU state
//   x, y                 current cell (registered)
//   bloqueado            high while a wall hit is pending release (BATEU)
//   chegou               high while parked on the target (CHEGOU)
//   acao_invalida        one-cycle pulse for each invalid acao sample
//   passos               saturating count of successful steps
module posicao
  import robo_pkg::*;
#(
  parameter int unsigned LARG = 8,
  parameter int unsigned ALT  = 8,
  parameter int unsigned X0   = 0,
  parameter int unsigned Y0   = 0,
  parameter int unsigned WX   = $clog2(LARG),
  parameter int unsigned WY   = $clog2(ALT)
) (
  input  logic                c4,
  input  logic                reset,
  input  logic [ACAO_W-1:0]   acao,
  input  logic [WX-1:0]       alvo_x,
  input  logic [WY-1:0]       alvo_y,
  input  logic                novo_alvo,
  output logic [WX-1:0]       x,
  output logic [WY-1:0]       y,
  output logic                bloqueado,
  output logic                chegou,
  output logic                acao_invalida,
  output logic [PASSOS_W-1:0] passos
);

  estado_pos_t   estado;
  logic [WX-1:0] nx;
  logic [WY-1:0] ny;
  logic          fora_da_grade;
  logic          codigo_invalido;

  proxima_posicao #(
    .LARG (LARG),
    .ALT  (ALT),
    .WX   (WX),
    .WY   (WY)
  ) u_proxima (
    .x               (x),
    .y               (y),
    .acao            (acao),
    .nx              (nx),
    .ny              (ny),
    .fora_da_grade   (fora_da_grade),
    .codigo_invalido (codigo_invalido)
  );

  // FSM, coordinate registers, step counter and target comparison
  always_ff @(posedge c4) begin
    if (reset) begin
      estado        <= LIVRE;
      x             <= WX'(X0);
      y             <= WY'(Y0);
      passos        <= '0;
      bloqueado     <= 1'b0;
      chegou        <= 1'b0;
      acao_invalida <= 1'b0;
    end else begin
      acao_invalida <= codigo_invalido;
      case (estado)
        LIVRE: begin
          if (eh_passo(acao)) begin
            if (fora_da_grade) begin
              estado    <= BATEU;
              bloqueado <= 1'b1;
            end else begin
              x <= nx;
              y <= ny;
              if (passos != PASSOS_MAX) passos <= passos + PASSOS_W'(1);
              // Arrival is judged on the cell being entered, so chegou
              // rises on the same edge as the move.
              if ((nx == alvo_x) && (ny == alvo_y)) begin
                estado <= CHEGOU;
                chegou <= 1'b1;
              end
            end
          end else if ((acao == PARADO) && (x == alvo_x) && (y == alvo_y)) begin
            // Idle on the target, e.g. a target equal to the reset cell
            estado <= CHEGOU;
            chegou <= 1'b1;
          end
        end
        BATEU: begin
          if (acao == PARADO) begin
            estado    <= LIVRE;
            bloqueado <= 1'b0;
          end
        end
        CHEGOU: begin
          if (novo_alvo) begin
            estado <= LIVRE;
            chegou <= 1'b0;
          end
        end
        default: begin
          estado    <= LIVRE;
          bloqueado <= 1'b0;
          chegou    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_posicao.sv
// Self-checking bench for posicao: directed scenarios plus a randomized run
// against a behavioural model of the grid walker.
module tb_posicao;

  logic       c4;
  logic       reset;
  logic [2:0] acao;
  logic [2:0] alvo_x;
  logic [2:0] alvo_y;
  logic       novo_alvo;
  logic [2:0] x;
  logic [2:0] y;
  logic       bloqueado;
  logic       chegou;
  logic       acao_invalida;
  logic [7:0] passos;

  int n_vec  = 0;
  int n_fail = 0;

  // behavioural model state (mode: 0 free, 1 blocked, 2 arrived)
  int m_x, m_y, m_passos, m_mode, m_inv;

  posicao dut (
    .c4            (c4),
    .reset         (reset),
    .acao          (acao),
    .alvo_x        (alvo_x),
    .alvo_y        (alvo_y),
    .novo_alvo     (novo_alvo),
    .x             (x),
    .y             (y),
    .bloqueado     (bloqueado),
    .chegou        (chegou),
    .acao_invalida (acao_invalida),
    .passos        (passos)
  );

  initial c4 = 1'b0;
  always #5 c4 = ~c4;

  // One clock edge; outputs are observed 1 time unit after it.
  task automatic tick();
    @(posedge c4);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1; acao = 3'd0; novo_alvo = 1'b0;
    tick();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1; acao = 3'd0; novo_alvo = 1'b0; alvo_x = 3'd7; alvo_y = 3'd7;
    tick(); tick();
    n_vec++;
    if (x !== 3'd0 || y !== 3'd0 || passos !== 8'd0 || bloqueado !== 1'b0 ||
        chegou !== 1'b0 || acao_invalida !== 1'b0) begin
      n_fail++;
      $display("FAIL reset: x=%0d y=%0d passos=%0d bloq=%b chegou=%b inv=%b, required 0 0 0 0 0 0",
               x, y, passos, bloqueado, chegou, acao_invalida);
    end
    reset = 1'b0;
  endtask

  task automatic test_norte();
    acao = 3'b001;
    for (int i = 1; i <= 3; i++) begin
      tick();
      n_vec++;
      if (y !== 3'(i) || x !== 3'd0) begin
        n_fail++;
        $display("FAIL norte step %0d: x=%0d y=%0d, required x=0 y=%0d", i, x, y, i);
      end
    end
    n_vec++;
    if (passos !== 8'd3) begin
      n_fail++;
      $display("FAIL norte passos: got %0d, required 3", passos);
    end
    acao = 3'd0;
    tick();
  endtask

  task automatic test_parede();
    alvo_x = 3'd7; alvo_y = 3'd7;
    do_reset();
    acao = 3'b010;
    tick();
    n_vec++;
    if (bloqueado !== 1'b1 || x !== 3'd0 || passos !== 8'd0) begin
      n_fail++;
      $display("FAIL parede hit: bloq=%b x=%0d passos=%0d, required 1 0 0", bloqueado, x, passos);
    end
    acao = 3'b011;
    for (int i = 0; i < 2; i++) begin
      tick();
      n_vec++;
      if (x !== 3'd0 || bloqueado !== 1'b1) begin
        n_fail++;
        $display("FAIL parede ignore %0d: x=%0d bloq=%b, required x=0 bloq=1", i, x, bloqueado);
      end
    end
    acao = 3'd0;
    tick();
    n_vec++;
    if (bloqueado !== 1'b0) begin
      n_fail++;
      $display("FAIL parede release: bloq=%b, required 0", bloqueado);
    end
  endtask

  task automatic test_chegada();
    alvo_x = 3'd2; alvo_y = 3'd0;
    do_reset();
    acao = 3'b011;
    tick();
    n_vec++;
    if (x !== 3'd1 || chegou !== 1'b0) begin
      n_fail++;
      $display("FAIL chegada step1: x=%0d chegou=%b, required x=1 chegou=0", x, chegou);
    end
    tick();
    n_vec++;
    if (x !== 3'd2 || chegou !== 1'b1 || passos !== 8'd2) begin
      n_fail++;
      $display("FAIL chegada arrive: x=%0d chegou=%b passos=%0d, required 2 1 2", x, chegou, passos);
    end
    acao = 3'b001;
    tick();
    n_vec++;
    if (y !== 3'd0 || chegou !== 1'b1 || passos !== 8'd2) begin
      n_fail++;
      $display("FAIL chegada frozen: y=%0d chegou=%b passos=%0d, required 0 1 2", y, chegou, passos);
    end
    novo_alvo = 1'b1;
    tick();
    novo_alvo = 1'b0;
    n_vec++;
    if (chegou !== 1'b0 || y !== 3'd0) begin
      n_fail++;
      $display("FAIL chegada release: chegou=%b y=%0d, required 0 0", chegou, y);
    end
    tick();
    n_vec++;
    if (y !== 3'd1 || passos !== 8'd3) begin
      n_fail++;
      $display("FAIL chegada resume: y=%0d passos=%0d, required 1 3", y, passos);
    end
    acao = 3'd0;
  endtask

  task automatic test_saturacao();
    alvo_x = 3'd7; alvo_y = 3'd7;
    do_reset();
    for (int i = 0; i < 300; i++) begin
      acao = (i % 2 == 0) ? 3'b011 : 3'b010;
      tick();
      n_vec++;
      if (passos !== 8'((i + 1 > 255) ? 255 : i + 1)) begin
        n_fail++;
        $display("FAIL saturacao cycle %0d: passos=%0d, required %0d", i, passos,
                 (i + 1 > 255) ? 255 : i + 1);
      end
    end
    acao = 3'd0;
    tick();
  endtask

  task automatic test_invalido_reset();
    alvo_x = 3'd7; alvo_y = 3'd7;
    do_reset();
    acao = 3'b011;
    repeat (3) tick();
    acao = 3'b001;
    repeat (3) tick();
    acao = 3'b101;
    tick();
    n_vec++;
    if (acao_invalida !== 1'b1 || x !== 3'd3 || y !== 3'd3) begin
      n_fail++;
      $display("FAIL invalido pulse: inv=%b x=%0d y=%0d, required 1 3 3", acao_invalida, x, y);
    end
    acao = 3'd0;
    tick();
    n_vec++;
    if (acao_invalida !== 1'b0) begin
      n_fail++;
      $display("FAIL invalido one-cycle: inv=%b, required 0", acao_invalida);
    end
    acao = 3'b001; reset = 1'b1;
    tick();
    reset = 1'b0; acao = 3'd0;
    n_vec++;
    if (x !== 3'd0 || y !== 3'd0 || passos !== 8'd0) begin
      n_fail++;
      $display("FAIL reset priority: x=%0d y=%0d passos=%0d, required 0 0 0", x, y, passos);
    end
  endtask

  // Model: apply one clock edge using the sampled inputs.
  task automatic model_edge(input int r, input int a, input int nv, input int ax, input int ay);
    int dx, dy, tx, ty;
    if (r != 0) begin
      m_x = 0; m_y = 0; m_passos = 0; m_mode = 0; m_inv = 0;
      return;
    end
    m_inv = (a >= 5) ? 1 : 0;
    dx = 0; dy = 0;
    if (a == 1) dy = 1;
    if (a == 4) dy = -1;
    if (a == 3) dx = 1;
    if (a == 2) dx = -1;
    if (m_mode == 0) begin
      if (a >= 1 && a <= 4) begin
        tx = m_x + dx; ty = m_y + dy;
        if (tx >= 0 && tx < 8 && ty >= 0 && ty < 8) begin
          m_x = tx; m_y = ty;
          if (m_passos < 255) m_passos++;
          if (tx == ax && ty == ay) m_mode = 2;
        end else begin
          m_mode = 1;
        end
      end else if (a == 0 && m_x == ax && m_y == ay) begin
        m_mode = 2;
      end
    end else if (m_mode == 1) begin
      if (a == 0) m_mode = 0;
    end else begin
      if (nv != 0) m_mode = 0;
    end
  endtask

  task automatic test_aleatorio();
    int r;
    alvo_x = 3'($urandom_range(0, 7)); alvo_y = 3'($urandom_range(0, 7));
    do_reset();
    model_edge(1, 0, 0, 0, 0);
    for (int i = 0; i < 3000; i++) begin
      r = int'($urandom_range(0, 99));
      if (r < 25)      acao = 3'd0;
      else if (r < 30) acao = 3'($urandom_range(5, 7));
      else             acao = 3'($urandom_range(1, 4));
      novo_alvo = ($urandom_range(0, 7) == 0);
      reset = ($urandom_range(0, 199) == 0);
      if ($urandom_range(0, 39) == 0) begin
        alvo_x = 3'($urandom_range(0, 7));
        alvo_y = 3'($urandom_range(0, 7));
      end
      tick();
      model_edge(int'(reset), int'(acao), int'(novo_alvo), int'(alvo_x), int'(alvo_y));
      n_vec++;
      if (x !== 3'(m_x) || y !== 3'(m_y) || passos !== 8'(m_passos) ||
          bloqueado !== (m_mode == 1) || chegou !== (m_mode == 2) ||
          acao_invalida !== 1'(m_inv)) begin
        n_fail++;
        $display("FAIL random cycle %0d: x=%0d y=%0d passos=%0d bloq=%b chegou=%b inv=%b, required %0d %0d %0d %0d %0d %0d",
                 i, x, y, passos, bloqueado, chegou, acao_invalida,
                 m_x, m_y, m_passos, (m_mode == 1), (m_mode == 2), m_inv);
      end
    end
    reset = 1'b0; acao = 3'd0; novo_alvo = 1'b0;
  endtask

  initial begin
    reset = 1'b1; acao = 3'd0; novo_alvo = 1'b0; alvo_x = 3'd7; alvo_y = 3'd7;
    test_reset();
    test_norte();
    test_parede();
    test_chegada();
    test_saturacao();
    test_invalido_reset();
    test_aleatorio();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
